// File: rtl/barrelshifter_pipelined_if.sv
// Valid/ready bundle between operand issue, the pipelined barrel shifter and ALU writeback.
// The shifter connects through the slave modport; the issue/writeback side uses master.
interface barrelshifter_pipelined_if #(
  parameter int D_SIZE = 32
) ();
  localparam int SW = $clog2(D_SIZE);

  logic [D_SIZE-1:0] x_in;
  logic [SW-1:0]     s_in;
  logic [2:0]        op_in;
  logic              valid_in;
  logic              ready_out;
  logic [D_SIZE-1:0] y_out;
  logic              zf_out;
  logic              vf_out;
  logic              cf_out;
  logic              valid_out;
  logic              ready_in;

  modport master (
    output x_in, s_in, op_in, valid_in, ready_in,
    input  ready_out, y_out, zf_out, vf_out, cf_out, valid_out
  );

  modport slave (
    input  x_in, s_in, op_in, valid_in, ready_in,
    output ready_out, y_out, zf_out, vf_out, cf_out, valid_out
  );
endinterface

// File: rtl/barrelshifter_pipelined.sv
// Pipelined barrel shifter: log2(D_SIZE) mux levels spread over PIPE register stages,
// six shift/rotate ops, zero/overflow/carry flags, valid/ready with full backpressure.
module barrelshifter_pipelined #(
  parameter int D_SIZE = 32,
  parameter int PIPE   = 2
) (
  input logic                      clk_in,
  input logic                      rst_in,
  barrelshifter_pipelined_if.slave bus
);
  localparam int L    = $clog2(D_SIZE);
  localparam int BASE = L / PIPE;
  localparam int REM  = L % PIPE;
  localparam int MD   = (PIPE > 1) ? PIPE - 1 : 1;

  // The first REM stages each take one extra mux level.
  function automatic int stage_lo(input int j);
    return j * BASE + ((j < REM) ? j : REM);
  endfunction

  function automatic int stage_cnt(input int j);
    return BASE + ((j < REM) ? 1 : 0);
  endfunction

  function automatic logic [D_SIZE-1:0] shift_level(input logic [D_SIZE-1:0] d,
                                                    input int k,
                                                    input logic [2:0] op,
                                                    input logic sign);
    logic [2*D_SIZE-1:0] ext;
    int amt;
    amt = 1 << k;
    ext = '0;
    shift_level = d;
    if (!op[2]) begin
      if (op[1]) begin
        shift_level = (d >> amt) | (d << (D_SIZE - amt));
      end else begin
        ext = {{D_SIZE{sign & op[0]}}, d} >> amt;
        shift_level = ext[D_SIZE-1:0];
      end
    end else begin
      if (op[1]) shift_level = (d << amt) | (d >> (D_SIZE - amt));
      else       shift_level = d << amt;
    end
  endfunction

  // Returns {zf, vf, cf}; carry and overflow look at the original operand only.
  function automatic logic [2:0] calc_flags(input logic [D_SIZE-1:0] x,
                                            input logic [L-1:0] s,
                                            input logic [2:0] op,
                                            input logic [D_SIZE-1:0] y);
    logic [L-1:0] s_m1;
    logic [L-1:0] s_neg;
    logic zf, vf, cf;
    s_m1  = s - 1'b1;
    s_neg = '0 - s;
    zf = (y == '0);
    vf = 1'b0;
    cf = 1'b0;
    if (s != '0) begin
      cf = op[2] ? x[s_neg] : x[s_m1];
      if (op == 3'b101) begin
        for (int i = 0; i < D_SIZE - 1; i++) begin
          if (i >= D_SIZE - 1 - int'(s) && x[i] != x[D_SIZE-1]) vf = 1'b1;
        end
      end
    end
    return {zf, vf, cf};
  endfunction

  logic [D_SIZE-1:0] data_q [PIPE];
  logic [PIPE-1:0]   valid_q;
  logic [D_SIZE-1:0] x_q    [MD];
  logic [L-1:0]      s_q    [MD];
  logic [2:0]        op_q   [MD];
  logic              zf_q, vf_q, cf_q;

  logic [D_SIZE-1:0] in_data  [PIPE];
  logic [D_SIZE-1:0] in_x     [PIPE];
  logic [L-1:0]      in_s     [PIPE];
  logic [2:0]        in_op    [PIPE];
  logic [PIPE-1:0]   in_valid;
  logic [D_SIZE-1:0] nxt_data [PIPE];
  logic [2:0]        nxt_flags;
  logic              advance;

  assign advance = !valid_q[PIPE-1] || bus.ready_in;

  always_comb begin
    in_data[0]  = bus.x_in;
    in_x[0]     = bus.x_in;
    in_s[0]     = bus.s_in;
    in_op[0]    = bus.op_in;
    in_valid[0] = bus.valid_in;
    for (int j = 1; j < PIPE; j++) begin
      in_data[j]  = data_q[j-1];
      in_x[j]     = x_q[j-1];
      in_s[j]     = s_q[j-1];
      in_op[j]    = op_q[j-1];
      in_valid[j] = valid_q[j-1];
    end
  end

  always_comb begin
    for (int j = 0; j < PIPE; j++) begin
      nxt_data[j] = in_data[j];
      for (int k = 0; k < L; k++) begin
        if (k >= stage_lo(j) && k < stage_lo(j) + stage_cnt(j) && in_s[j][k])
          nxt_data[j] = shift_level(nxt_data[j], k, in_op[j], in_x[j][D_SIZE-1]);
      end
    end
    // SLA runs through the SLL datapath and restores the sign bit at the end.
    if (in_op[PIPE-1] == 3'b101)
      nxt_data[PIPE-1][D_SIZE-1] = in_x[PIPE-1][D_SIZE-1];
    nxt_flags = calc_flags(in_x[PIPE-1], in_s[PIPE-1], in_op[PIPE-1], nxt_data[PIPE-1]);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      valid_q <= '0;
      zf_q    <= 1'b0;
      vf_q    <= 1'b0;
      cf_q    <= 1'b0;
      for (int j = 0; j < PIPE; j++) data_q[j] <= '0;
      for (int j = 0; j < MD; j++) begin
        x_q[j]  <= '0;
        s_q[j]  <= '0;
        op_q[j] <= '0;
      end
    end else if (advance) begin
      valid_q <= in_valid;
      {zf_q, vf_q, cf_q} <= nxt_flags;
      for (int j = 0; j < PIPE; j++) data_q[j] <= nxt_data[j];
      for (int j = 0; j < MD; j++) begin
        x_q[j]  <= in_x[j];
        s_q[j]  <= in_s[j];
        op_q[j] <= in_op[j];
      end
    end
  end

  assign bus.ready_out = advance;
  assign bus.valid_out = valid_q[PIPE-1];
  assign bus.y_out     = data_q[PIPE-1];
  assign bus.zf_out    = zf_q;
  assign bus.vf_out    = vf_q;
  assign bus.cf_out    = cf_q;
endmodule
